instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the multicycle RV32I core, directly upstream of the instruction handler.
- Owns the program counter and runs a request/acknowledge handshake with instruction memory.
- Delivers each fetched word on instr_out, with a one-cycle instr_fetch strobe that drives the handler's in_instruction/fetch inputs.
- The control FSM starts each fetch and redirects the PC for branches and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT_CYC, 16, REQ cycles without ack before error; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  control FSM request to fetch the word at the current PC.
- pc_load  in  1  load PC from pc_next_in.
- pc_next_in  in  32  branch/jump target.
- imem_req  out  1  memory request, held until ack.
- imem_addr  out  32  fetch address, stable while imem_req=1.
- imem_ack  in  1  memory data valid this cycle.
- imem_rdata  in  32  memory read data.
- instr_out  out  32  captured instruction, to handler in_instruction.
- instr_fetch  out  1  one-cycle strobe, to handler fetch.
- pc_out  out  32  address of the instruction on instr_out.
- pc_plus4  out  32  pc_out+4, combinational, for JAL/JALR link.
- busy  out  1  high in REQ or DONE.
- fetch_err  out  1  sticky fetch error.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous and active-high: sampled on the rising edge of clk.
- Reset values:
  - State IDLE.
  - pc, imem_addr and pc_out = RESET_PC.
  - instr_out = 32'h0000_0013 (NOP).
  - imem_req, instr_fetch, busy and fetch_err = 0.
  - Timeout counter = 0.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - pc_load=1: pc <= pc_next_in.
  - fetch_start=1: if the effective PC has [1:0]==0, go to REQ with imem_addr <= effective PC and imem_req <= 1. Otherwise go to ERR.
  - Effective PC is pc_next_in when pc_load is also high, else pc. pc_load is applied first.
- REQ:
  - imem_req stays 1 and imem_addr stays stable.
  - imem_ack=1: instr_out <= imem_rdata, pc_out <= imem_addr, imem_req <= 0, go to DONE.
  - fetch_start and pc_load are ignored.
- DONE (exactly one cycle):
  - instr_fetch=1.
  - pc <= pc+4, with modulo-2^32 wrap: 32'hFFFF_FFFC -> 32'h0.
  - pc_load=1 in this cycle wins over +4.
  - Return to IDLE.
- ERR:
  - fetch_err=1 and imem_req=0.
  - Leave only by rst, or by pc_load with pc_next_in[1:0]==0, which loads the PC, clears fetch_err and returns to IDLE.
  - fetch_start is ignored.
- Latency: fetch_start at cycle N and ack at N+1 give instr_fetch at N+2. Each extra wait cycle adds one.
- imem_ack outside REQ is ignored.
- instr_out and pc_out hold their values between fetches.
- Reset mid-REQ: state returns to IDLE and imem_req drops at that edge. A late ack is ignored.
- busy = (state==REQ) || (state==DONE).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: the counter increments every REQ cycle without ack and clears on leaving REQ. When it reaches TIMEOUT_CYC-1 without ack, the next edge goes to ERR with imem_req=0.
- Not defined: no counter is built, and REQ waits indefinitely for ack.

Decomposition:
- Shared package fetch_pkg:
  - State enum.
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - ALIGN_MASK = 2'b11.
- Sub-module pc_reg: PC register with load, +4 increment and reset-to-RESET_PC. The FSM and capture registers remain in instr_fetch_unit.

Test Plan:
- Reset then fetch_start, ack one cycle later with rdata=32'h00500093 -> imem_addr=0, instr_fetch pulse 2 cycles after start, instr_out=32'h00500093, pc_out=0, next imem_addr=4.
- Ack delayed 5 cycles -> imem_req held 6 cycles, imem_addr constant, busy high throughout, a single instr_fetch pulse.
- pc_load with 32'h0000_0100 together with fetch_start in IDLE -> imem_addr=0x100; pc_load during REQ -> ignored.
- pc_load with 32'h0000_0102 then fetch_start -> ERR, fetch_err=1, no imem_req; pc_load 32'h0000_0200 -> fetch_err=0, next fetch from 0x200.
- PC 32'hFFFF_FFFC fetch completes -> pc wraps to 0 and pc_plus4=0 for that instruction; rst asserted mid-REQ -> imem_req=0 next edge, a late ack produces no instr_fetch.
- FETCH_TIMEOUT_EN with TIMEOUT_CYC=16, no ack -> ERR after 16 REQ cycles; macro undefined -> still in REQ after 100 cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by this slice: FETCH_TIMEOUT_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK     = 2'b11;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface instr_fetch_unit_if;

  // Handshake: the master raises imem_req with imem_addr and holds both stable
  // until a cycle in which the slave asserts imem_ack; imem_rdata is valid
  // only in that cycle, and req drops on the following edge. An ack while req
  // is low carries no meaning and is ignored.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: reset value, explicit load, and +4 advance.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        inc,
  output logic [31:0] pc
);

  // Load has priority over increment; the add wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake and strobes each
// fetched word to the handler. Optional REQ timeout under FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = FETCH_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_start,
  input  logic                      pc_load,
  input  logic [31:0]               pc_next_in,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               instr_out,
  output logic                      instr_fetch,
  output logic [31:0]               pc_out,
  output logic [31:0]               pc_plus4,
  output logic                      busy,
  output logic                      fetch_err,
  output fetch_state_e              state_dbg
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT_CYC must be at least 1");
  end

  fetch_state_e state, state_nxt;

  logic [31:0] pc;
  logic [31:0] eff_pc;
  logic [31:0] addr_q;
  logic        start_ok;
  logic        req_ack;
  logic        load_ok;
  logic        pc_load_en;
  logic        pc_inc;
  logic        timeout_hit;

  // A pc_load arriving with fetch_start in IDLE retargets that same fetch.
  assign eff_pc   = pc_load ? pc_next_in : pc;
  assign start_ok = is_aligned(eff_pc);
  assign req_ack  = (state == REQ) && imem.imem_ack;
  assign load_ok  = pc_load && is_aligned(pc_next_in);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load_en),
    .load_val (pc_next_in),
    .inc      (pc_inc),
    .pc       (pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state != REQ)) begin
      to_cnt <= '0;
    end else if (!imem.imem_ack && (to_cnt != TO_LAST)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == REQ) && !imem.imem_ack && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetch_start) begin
          state_nxt = start_ok ? REQ : ERR;
        end
      end
      REQ: begin
        if (imem.imem_ack) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      DONE: state_nxt = IDLE;
      ERR: begin
        if (load_ok) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = (state == REQ);
    instr_fetch   = (state == DONE);
    busy          = (state == REQ) || (state == DONE);
    fetch_err     = (state == ERR);
    pc_inc        = (state == DONE);
    pc_load_en    = 1'b0;
    case (state)
      IDLE:    pc_load_en = pc_load;
      DONE:    pc_load_en = pc_load;
      ERR:     pc_load_en = load_ok;
      default: pc_load_en = 1'b0;
    endcase
  end

  // Address is latched on entry to REQ and held until the next fetch starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= RESET_PC;
      instr_out <= NOP_INSTR;
      pc_out    <= RESET_PC;
    end else begin
      if ((state == IDLE) && fetch_start && start_ok) begin
        addr_q <= eff_pc;
      end
      if (req_ack) begin
        instr_out <= imem.imem_rdata;
        pc_out    <= addr_q;
      end
    end
  end

  assign imem.imem_addr = addr_q;
  assign pc_plus4       = pc_out + 32'd4;
  assign state_dbg      = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default build; the
// FETCH_TIMEOUT_EN branch checks the timeout path when that macro is set).
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_next_in;
  logic [31:0] instr_out;
  logic        instr_fetch;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        fetch_err;
  fetch_state_e state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .pc_next_in  (pc_next_in),
    .imem        (bus),
    .instr_out   (instr_out),
    .instr_fetch (instr_fetch),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic pl, input logic [31:0] pn,
                       input logic ack, input logic [31:0] rdata);
    fetch_start    = fs;
    pc_load        = pl;
    pc_next_in     = pn;
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_fetch", 32'(instr_fetch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_plus4", pc_plus4, 32'h4);

    // Basic fetch, ack one cycle after start
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("f1_req", 32'(bus.imem_req), 32'd1);
    chk("f1_addr", bus.imem_addr, 32'h0);
    chk("f1_fetch_early", 32'(instr_fetch), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
    tick();
    chk("f1_fetch", 32'(instr_fetch), 32'd1);
    chk("f1_instr", instr_out, 32'h0050_0093);
    chk("f1_pc_out", pc_out, 32'h0);
    chk("f1_req_drop", 32'(bus.imem_req), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("f1_fetch_end", 32'(instr_fetch), 32'd0);
    chk("f1_idle", 32'(state_dbg), 32'(IDLE));

    // Second fetch at PC+4 with the ack delayed five cycles
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("f2_addr", bus.imem_addr, 32'h4);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("f2_req_hold", 32'(bus.imem_req), 32'd1);
      chk("f2_addr_hold", bus.imem_addr, 32'h4);
      chk("f2_busy", 32'(busy), 32'd1);
      chk("f2_no_fetch", 32'(instr_fetch), 32'd0);
      tick();
    end
    chk("f2_req_6th", 32'(bus.imem_req), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0113);
    tick();
    chk("f2_fetch", 32'(instr_fetch), 32'd1);
    chk("f2_instr", instr_out, 32'h00A0_0113);
    chk("f2_pc_out", pc_out, 32'h4);
    chk("f2_busy_done", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("f2_fetch_end", 32'(instr_fetch), 32'd0);
    chk("f2_busy_idle", 32'(busy), 32'd0);

    // Ack outside REQ is ignored
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    tick();
    chk("ack_idle_fetch", 32'(instr_fetch), 32'd0);
    chk("ack_idle_instr", instr_out, 32'h00A0_0113);
    chk("ack_idle_state", 32'(state_dbg), 32'(IDLE));

    // pc_load together with fetch_start; pc_load during REQ ignored
    drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    tick();
    chk("ld_addr", bus.imem_addr, 32'h100);
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    tick();
    chk("ld_req_ign_state", 32'(state_dbg), 32'(REQ));
    chk("ld_req_ign_addr", bus.imem_addr, 32'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0010_0193);
    tick();
    chk("ld_pc_out", pc_out, 32'h100);
    chk("ld_plus4", pc_plus4, 32'h104);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("ld_next_addr", bus.imem_addr, 32'h104);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // Misaligned target -> ERR, recovery by an aligned pc_load
    drive(1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    tick();
    chk("err_state", 32'(state_dbg), 32'(ERR));
    chk("err_flag", 32'(fetch_err), 32'd1);
    chk("err_no_req", 32'(bus.imem_req), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_start_ign", 32'(bus.imem_req), 32'd0);
    drive(1'b0, 1'b1, 32'h0000_0106, 1'b0, 32'h0);
    tick();
    chk("err_bad_load", 32'(fetch_err), 32'd1);
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    tick();
    chk("err_clear", 32'(fetch_err), 32'd0);
    chk("err_idle", 32'(state_dbg), 32'(IDLE));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("err_next_addr", bus.imem_addr, 32'h200);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // PC wrap at the top of the address space
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_006F);
    tick();
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("wrap_next_addr", bus.imem_addr, 32'h0);

    // pc_load during DONE wins over +4
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
    tick();
    chk("done_fetch", 32'(instr_fetch), 32'd1);
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("done_load_addr", bus.imem_addr, 32'h40);

    // Reset mid-REQ, then a late ack
    chk("mid_req", 32'(bus.imem_req), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    tick();
    chk("late_ack_fetch", 32'(instr_fetch), 32'd0);
    chk("late_ack_instr", instr_out, 32'h0000_0013);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("late_ack_fetch2", 32'(instr_fetch), 32'd0);

    // No ack at all
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_req", 32'(bus.imem_req), 32'd1);
      tick();
    end
    chk("to_last_req", 32'(state_dbg), 32'(REQ));
    tick();
    chk("to_err_state", 32'(state_dbg), 32'(ERR));
    chk("to_err_flag", 32'(fetch_err), 32'd1);
    chk("to_err_req", 32'(bus.imem_req), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
    end
    chk("noto_state", 32'(state_dbg), 32'(REQ));
    chk("noto_req", 32'(bus.imem_req), 32'd1);
    chk("noto_err", 32'(fetch_err), 32'd0);
    chk("noto_busy", 32'(busy), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
